// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus start sequencer feeding an adjacent uart_tx.
// Pops one byte at a time and tracks uart_tx rdy before the next pop.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_ovf_clr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_idle,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_rdy
);

    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = CNT_ONE[DEPTH_LOG2-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            mem_q [2**DEPTH_LOG2];

    logic full, empty, push, pop;

    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
        // Full is judged on the registered count, so a same-cycle pop never rescues a push.
        push  = i_wr & ~full;
        pop   = (state_q == S_IDLE) & ~empty & i_tx_rdy;

        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (i_wr & full) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pop) state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY:  if (!i_tx_rdy) state_d = S_DONE;
            S_DONE:  if (i_tx_rdy) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_full     = full;
    assign o_empty    = empty;
    assign o_level    = count_q;
    assign o_overflow = ovf_q;
    assign o_idle     = empty & (state_q == S_IDLE);
    assign o_tx_start = (state_q == S_START);
    assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue reference model plus a behavioural uart_tx rdy.
// Scenario tasks run in sequence and compare DUT outputs against the model.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_rdy = 1'b1;

    logic        o_full, o_empty, o_overflow, o_idle, o_tx_start;
    logic [DL:0] o_level;
    logic [7:0]  o_tx_data;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr       (wr),
        .i_wr_data  (wr_data),
        .i_ovf_clr  (ovf_clr),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_idle     (o_idle),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_rdy   (tx_rdy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: accepted-but-unsent bytes, and the cycle the
    // sequencer may next pop (start + rdy-low time + 2 handshake cycles).
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_start = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         cyc = 0;
    int         t_idle = 0;
    int         busy = 0;
    int         frame = 4;
    logic       hold = 1'b0;

    wire [17:0] obs = {o_tx_start, o_tx_data, o_level,
                       o_full, o_empty, o_overflow, o_idle};

    function automatic logic [17:0] exp_vec();
        int n;
        n = q.size();
        return {m_start, m_data, 5'(n), n == DEPTH, n == 0,
                m_ovf, (n == 0) && (cyc >= t_idle)};
    endfunction

    task automatic set_hold(input logic b);
        hold   = b;
        tx_rdy = (busy == 0) && !hold;
    endtask

    task automatic tick();
        logic st;
        logic pop;
        logic full;
        st   = o_tx_start;
        full = (q.size() == DEPTH);
        if (!rst_n) begin
            q.delete();
            m_ovf   = 1'b0;
            m_start = 1'b0;
            m_data  = 8'h00;
            t_idle  = cyc + 1;
        end else begin
            pop = (cyc >= t_idle) && (q.size() > 0) && tx_rdy;
            if (wr && full) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_start = pop;
            if (pop) begin
                m_data = q.pop_front();
                t_idle = cyc + 1 + frame + 2;
            end
            if (wr && !full) q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (st === 1'b1) busy = frame;
        else if (busy > 0) busy--;
        tx_rdy = (busy == 0) && !hold;
    endtask

    task automatic settle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (q.size() == 0 && cyc >= t_idle && busy == 0 && !m_start) begin
                to = 1'b0;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr = 1'b0;
        ovf_clr = 1'b0;
        set_hold(1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if (obs !== 18'b0_00000000_00000_0_1_0_1) begin
            miscompares++;
            $display("FAIL reset_const got=%h exp=%h", obs, 18'b0_00000000_00000_0_1_0_1);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        int n0, sc;
        bit to;
        sc = -1;
        n0 = cyc;
        wr = 1'b1;
        wr_data = 8'h55;
        tick();
        wr = 1'b0;
        vectors++;
        if (o_level !== 5'd1) begin
            miscompares++;
            $display("FAIL single_level1 got=%0d exp=1", o_level);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_cyc%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (o_tx_start === 1'b1 && sc < 0) begin
                sc = cyc;
                vectors++;
                if (o_tx_data !== 8'h55 || o_level !== 5'd0) begin
                    miscompares++;
                    $display("FAIL single_data got=%h/%0d exp=55/0", o_tx_data, o_level);
                end
            end
            tick();
        end
        vectors++;
        if (sc - n0 != 2) begin
            miscompares++;
            $display("FAIL single_latency got=%0d exp=2", sc - n0);
        end
        settle(to);
        vectors++;
        if (to || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_settle to=%0d got=%h exp=%h", to, obs, exp_vec());
        end
    endtask

    task automatic test_overflow();
        int k;
        bit to;
        frame = 2;
        set_hold(1'b1);
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1;
            wr_data = 8'(i);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_fill%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (o_full !== 1'b1 || o_level !== 5'd16 || o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full got=%b/%0d/%b exp=1/16/0", o_full, o_level, o_overflow);
        end
        wr_data = 8'hAA;
        tick();
        wr = 1'b0;
        vectors++;
        if (o_overflow !== 1'b1 || o_level !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_drop got=%b/%0d exp=1/16", o_overflow, o_level);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got=%b exp=0", o_overflow);
        end
        wr = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr = 1'b0;
        ovf_clr = 1'b0;
        vectors++;
        if (o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins got=%b exp=1", o_overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        set_hold(1'b0);
        k = 1;
        for (int i = 0; i < 200 && k <= 16; i++) begin
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            if (o_tx_start === 1'b1) begin
                vectors++;
                if (o_tx_data !== 8'(k)) begin
                    miscompares++;
                    $display("FAIL ovf_order got=%h exp=%h", o_tx_data, 8'(k));
                end
                k++;
            end
            tick();
        end
        vectors++;
        if (k != 17) begin
            miscompares++;
            $display("FAIL ovf_count got=%0d exp=16", k - 1);
        end
        settle(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL ovf_settle got=timeout exp=quiet");
        end
    endtask

    task automatic test_stream();
        int dut_starts, mdl_starts;
        bit to;
        dut_starts = 0;
        mdl_starts = 0;
        frame = $urandom_range(1, 6);
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            if (o_tx_start === 1'b1) begin
                dut_starts++;
                vectors++;
                if (busy != 0) begin
                    miscompares++;
                    $display("FAIL stream_busy_start busy=%0d exp=0", busy);
                end
            end
            if (m_start) mdl_starts++;
        end
        wr = 1'b0;
        ovf_clr = 1'b0;
        settle(to);
        vectors++;
        if (to || dut_starts != mdl_starts) begin
            miscompares++;
            $display("FAIL stream_starts to=%0d got=%0d exp=%0d", to, dut_starts, mdl_starts);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] first;
        bit to;
        frame = 3;
        set_hold(1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            wr_data = 8'($urandom);
            if (i == 0) first = wr_data;
            tick();
        end
        wr_data = 8'hAB;
        set_hold(1'b0);
        tick();
        wr = 1'b0;
        vectors++;
        if (o_level !== 5'd15 || o_overflow !== 1'b1 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL fpp_level got=%0d/%b exp=15/1", o_level, o_overflow);
        end
        vectors++;
        if (o_tx_start !== 1'b1 || o_tx_data !== first) begin
            miscompares++;
            $display("FAIL fpp_start got=%b/%h exp=1/%h", o_tx_start, o_tx_data, first);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        settle(to);
        vectors++;
        if (to || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL fpp_settle to=%0d got=%h exp=%h", to, obs, exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        frame = 8;
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1;
            wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr = 1'b0;
        vectors++;
        if (o_level !== 5'd5 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL mrst_pre got=%0d exp=5", o_level);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (o_level !== 5'd0 || o_empty !== 1'b1 || o_tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_post got=%0d/%b/%b exp=0/1/0", o_level, o_empty, o_tx_start);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (o_tx_start !== 1'b0 || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL mrst_quiet cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
        end
        wr = 1'b1;
        wr_data = 8'hC3;
        tick();
        wr = 1'b0;
        tick();
        vectors++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL mrst_restart got=%b/%h exp=1/c3", o_tx_start, o_tx_data);
        end
        settle(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL mrst_settle got=timeout exp=quiet");
        end
    endtask

    task automatic test_rdy_hold();
        bit to;
        frame = 2;
        set_hold(1'b1);
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1;
            wr_data = 8'hE0 + 8'(i);
            tick();
        end
        wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (o_tx_start !== 1'b0 || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold_quiet cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
        end
        set_hold(1'b0);
        tick();
        vectors++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'hE0) begin
            miscompares++;
            $display("FAIL hold_release got=%b/%h exp=1/e0", o_tx_start, o_tx_data);
        end
        settle(to);
        vectors++;
        if (to || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL hold_settle to=%0d got=%h exp=%h", to, obs, exp_vec());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_stream();
        test_full_pushpop();
        test_mid_reset();
        test_rdy_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
